// File: rtl/ysyx_25060170_gpr_pkg.sv
// Shared core sizing for the register file and its users (IDU/EXU/WBU).
package ysyx_25060170_gpr_pkg;

  localparam int unsigned NREG   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/ysyx_25060170_gpr_scoreboard.sv
// Per-register busy tracking and issue stall generation.
module ysyx_25060170_gpr_scoreboard #(
  parameter int unsigned NREG   = ysyx_25060170_gpr_pkg::NREG,
  parameter int unsigned ADDR_W = ysyx_25060170_gpr_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] busy_eff;

  // Writeback clears its target this cycle, so a hazard on it is already resolved.
  // Set is OR-ed after clear so a same-index issue keeps the bit.
  // stall deliberately ignores issue_valid to avoid a loop through the IDU.
  always_comb begin
    clr_vec = '0;
    if (wr_en && (wr_addr != '0)) begin
      clr_vec[wr_addr] = 1'b1;
    end
    busy_eff = busy_q & ~clr_vec;
    stall = (rs1_used & busy_eff[rs1_addr]) |
            (rs2_used & busy_eff[rs2_addr]) |
            (issue_we & busy_eff[issue_rd]);
    set_vec = '0;
    if (issue_valid && issue_we && (issue_rd != '0) && !stall) begin
      set_vec[issue_rd] = 1'b1;
    end
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  // Busy vector register; reset drops any outstanding writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/ysyx_25060170_gpr.sv
// Integer register file: two bypassed read ports, one write port, a committed-state
// debug port, and a scoreboard that stalls issue on pending writebacks.
module ysyx_25060170_gpr #(
  parameter int unsigned NREG   = ysyx_25060170_gpr_pkg::NREG,
  parameter int unsigned ADDR_W = ysyx_25060170_gpr_pkg::ADDR_W,
  parameter int unsigned DATA_W = ysyx_25060170_gpr_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf_q [NREG];
  logic              wr_act;

  assign wr_act = wr_en && (wr_addr != '0);

  // Register array; x0 is cleared on reset and never written, so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_act) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  // Combinational reads with same-cycle writeback bypass; debug sees committed state only.
  always_comb begin
    rs1_data = rf_q[rs1_addr];
    rs2_data = rf_q[rs2_addr];
    if (wr_act && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
    end
    if (wr_act && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
    end
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end
    dbg_data = rf_q[dbg_addr];
  end

  ysyx_25060170_gpr_scoreboard #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .stall       (stall)
  );

endmodule

// File: tb/tb_ysyx_25060170_gpr.sv
// Directed bench for the GPR file and scoreboard.
module tb_ysyx_25060170_gpr;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_used;
  logic        rs2_used;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic        stall;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total;
  int bad;

  ysyx_25060170_gpr dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .stall       (stall),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rs1_used = 0; rs2_used = 0;
    issue_valid = 0; issue_we = 0; issue_rd = 0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1;
    rs1_addr = 0; rs2_addr = 0; dbg_addr = 0;
    idle();
    step();
    step();
    rst = 0;

    // Reset state of every index
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i); dbg_addr = 5'(i);
      rs1_used = 1; rs2_used = 1;
      #1;
      chk("rst_rs1", rs1_data, 32'h0);
      chk("rst_rs2", rs2_data, 32'h0);
      chk("rst_dbg", dbg_data, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
    end
    idle();

    // Write x5 with bypass; debug port sees old value until the edge
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    rs1_addr = 5; dbg_addr = 5;
    #1;
    chk("byp_rs1_x5", rs1_data, 32'hDEADBEEF);
    chk("dbg_x5_pre", dbg_data, 32'h0);
    step();
    idle();
    #1;
    chk("dbg_x5_post", dbg_data, 32'hDEADBEEF);
    chk("rs1_x5_post", rs1_data, 32'hDEADBEEF);

    // x0 write is dropped
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678;
    rs1_addr = 0; dbg_addr = 0;
    #1;
    chk("x0_byp", rs1_data, 32'h0);
    step();
    idle();
    #1;
    chk("x0_dbg", dbg_data, 32'h0);
    chk("x0_rs1", rs1_data, 32'h0);

    // RAW hazard on x7, resolved by writeback with bypass
    issue_valid = 1; issue_we = 1; issue_rd = 7;
    #1;
    chk("iss7_stall", {31'b0, stall}, 32'h0);
    step();
    idle();
    rs2_addr = 7; rs2_used = 1;
    #1;
    chk("x7_busy_stall", {31'b0, stall}, 32'h1);
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A50007;
    #1;
    chk("x7_wb_stall", {31'b0, stall}, 32'h0);
    chk("x7_wb_byp", rs2_data, 32'hA5A50007);
    step();
    idle();
    rs2_addr = 7; rs2_used = 1;
    #1;
    chk("x7_cleared", {31'b0, stall}, 32'h0);
    chk("x7_stored", rs2_data, 32'hA5A50007);

    // Stalled issue leaves the scoreboard untouched; WAW on issue_rd stalls too
    idle();
    issue_valid = 1; issue_we = 1; issue_rd = 11;
    step();
    idle();
    issue_we = 1; issue_rd = 11;
    #1;
    chk("waw11_stall", {31'b0, stall}, 32'h1);
    issue_valid = 1; issue_rd = 12; rs1_addr = 11; rs1_used = 1;
    #1;
    chk("raw11_stall", {31'b0, stall}, 32'h1);
    step();
    idle();
    rs2_addr = 12; rs2_used = 1;
    #1;
    chk("x12_not_set", {31'b0, stall}, 32'h0);

    // Simultaneous clear and set of x3: set wins
    idle();
    issue_valid = 1; issue_we = 1; issue_rd = 3;
    step();
    idle();
    wr_en = 1; wr_addr = 3; wr_data = 32'h00000033;
    issue_valid = 1; issue_we = 1; issue_rd = 3;
    #1;
    chk("x3_same_stall", {31'b0, stall}, 32'h0);
    step();
    idle();
    rs1_addr = 3; rs1_used = 1;
    #1;
    chk("x3_still_busy", {31'b0, stall}, 32'h1);
    chk("x3_data", rs1_data, 32'h00000033);

    // Write to a register that was never busy
    idle();
    wr_en = 1; wr_addr = 20; wr_data = 32'h00000020;
    step();
    idle();
    rs1_addr = 20; rs1_used = 1;
    #1;
    chk("x20_stall", {31'b0, stall}, 32'h0);
    chk("x20_data", rs1_data, 32'h00000020);

    // Reset mid-operation drops busy bits and data, ignoring concurrent write/issue
    idle();
    issue_valid = 1; issue_we = 1; issue_rd = 9;
    step();
    idle();
    rs1_addr = 9; rs1_used = 1;
    #1;
    chk("x9_busy", {31'b0, stall}, 32'h1);
    rst = 1;
    wr_en = 1; wr_addr = 9; wr_data = 32'hFFFF0009;
    issue_valid = 1; issue_we = 1; issue_rd = 13;
    dbg_addr = 5;
    #1;
    chk("rst_pre_dbg5", dbg_data, 32'hDEADBEEF);
    step();
    rst = 0;
    idle();
    rs1_addr = 9; rs1_used = 1; dbg_addr = 9;
    #1;
    chk("post_rst_x9_stall", {31'b0, stall}, 32'h0);
    chk("post_rst_x9_data", rs1_data, 32'h0);
    chk("post_rst_x9_dbg", dbg_data, 32'h0);
    rs1_addr = 3; rs2_addr = 11; rs2_used = 1; issue_we = 1; issue_rd = 13; dbg_addr = 5;
    #1;
    chk("post_rst_other_stall", {31'b0, stall}, 32'h0);
    chk("post_rst_dbg5", dbg_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_gpr.md
YSYX_25060170_GPR -- requirements
Module: ysyx_25060170_GPR

Interface
REQ-001 Parameter: NREG, 32, number of architectural registers.
REQ-002 Parameter: ADDR_W, 5, register index width.
REQ-003 Parameter: DATA_W, 32, register data width.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: wr_en  in  1  writeback enable, driven by WBU reg_write_en_o.
REQ-007 Port: wr_addr  in  ADDR_W  writeback destination index.
REQ-008 Port: wr_data  in  DATA_W  writeback data.
REQ-009 Port: rs1_addr, rs2_addr  in  ADDR_W  IDU source indices.
REQ-010 Port: rs1_used, rs2_used  in  1  source actually read by the decoded instruction.
REQ-011 Port: rs1_data, rs2_data  out  DATA_W  source operand values.
REQ-012 Port: issue_valid  in  1  IDU issues the decoded instruction this cycle.
REQ-013 Port: issue_we, issue_rd  in  1 / ADDR_W  issued instruction writes rd.
REQ-014 Port: stall  out  1  decoded instruction must not issue.
REQ-015 Port: dbg_addr  in  ADDR_W; dbg_data  out  DATA_W  difftest/trace read port.

Function
REQ-016 Storage SHALL be NREG x DATA_W; x0 SHALL read 0 always and SHALL never be written or marked busy.
REQ-017 Write: when wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data at the next rising edge.
REQ-018 Reads SHALL be combinational, zero latency.
REQ-019 Bypass: if wr_en=1, wr_addr!=0, wr_addr==rsN_addr, then rsN_data SHALL equal wr_data in the same cycle.
REQ-020 dbg_data SHALL return stored reg[dbg_addr] without bypass (committed state only).
REQ-021 Scoreboard: one busy bit per register, x0 bit constant 0.
REQ-022 Set: issue_valid=1, issue_we=1, issue_rd!=0 and stall=0 SHALL set busy[issue_rd] at the next edge.
REQ-023 Clear: wr_en=1, wr_addr!=0 SHALL clear busy[wr_addr] at the next edge.
REQ-024 Simultaneous set and clear of the same index: set SHALL win (busy=1 after the edge).
REQ-025 stall SHALL be combinational = (rs1_used & busy_eff[rs1_addr]) | (rs2_used & busy_eff[rs2_addr]) | (issue_we & busy_eff[issue_rd]), where busy_eff[i] = busy[i] & ~(wr_en & wr_addr==i).
REQ-026 stall SHALL NOT depend on issue_valid (no combinational loop through IDU).
REQ-027 issue_valid while stall=1 SHALL leave scoreboard unchanged.
REQ-028 A write to a non-busy register SHALL be accepted normally (no error, busy stays 0).

Reset
REQ-029 With rst=1 at a rising edge, all registers SHALL become 0 and all busy bits SHALL become 0.
REQ-030 During rst=1, writes and issues SHALL be ignored; outputs SHALL reflect the pre-edge state until the edge, then zeros; stall SHALL be 0 one cycle after reset.
REQ-031 Reset mid-operation SHALL discard outstanding busy bits; no late write is implied.

Structure
REQ-032 NREG, ADDR_W, DATA_W SHALL live in the shared core package used by IDU/EXU/WBU.
REQ-033 Scoreboard SHALL be a sub-module ysyx_25060170_Scoreboard (busy vector, set/clear, stall logic); data array and bypass stay in the top.

Verification
REQ-034 Reset, then read all 32 indices via rs1/rs2/dbg -> all 0, stall=0.
REQ-035 wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF, dbg_data(5)=0 that cycle, 0xDEADBEEF next cycle.
REQ-036 wr_en=1, wr_addr=0, wr_data=0x12345678 -> rs1_data(x0)=0, dbg_data(x0)=0 forever.
REQ-037 Issue issue_rd=7, issue_we=1; next cycle rs2_addr=7, rs2_used=1 -> stall=1; assert wr_en addr 7 -> stall=0 same cycle, rs2_data bypassed.
REQ-038 busy[3]=1; same cycle wr_en addr 3 and issue issue_rd=3 with stall=0 (no other hazard) -> busy[3]=1 after the edge; stall=0 only because busy_eff clears that cycle.
REQ-039 Issue rd=9, then rst=1 one cycle -> busy[9]=0, reg[9]=0, rs1_addr=9 rs1_used=1 -> stall=0.
